mem_stage: RTL and testbench

- MIPS-32 memory-access stage; sits directly downstream of the EX/MEM pipeline buffer and consumes its outputs.
- Resolves branches, performs word loads and stores against an internal data RAM, and detects illegal accesses.
- Registers its results into the MEM/WB pipeline register that feeds write-back.

---
 rtl/mem_stage_if.sv | 37 +++
 rtl/mem_stage.sv | 101 ++++++++++
 tb/tb_mem_stage.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM stage bus: pipeline inputs from EX/MEM plus the branch,
// MEM/WB and fault/statistics outputs of the memory stage.
interface mem_stage_if #(
  parameter int CNT_W = 16
);
  // From EX/MEM
  logic [2:0]       M;
  logic [2:0]       WB;
  logic [31:0]      Add_result;
  logic             zero;
  logic [31:0]      Alu_result;
  logic [31:0]      Dato2;
  logic [4:0]       Direccion;
  // From the memory stage
  logic             pc_src;
  logic [31:0]      branch_target;
  logic [2:0]       WB_out;
  logic [31:0]      Read_data_out;
  logic [31:0]      Alu_result_out;
  logic [4:0]       Direccion_out;
  logic             mem_fault;
  logic [31:0]      fault_addr;
  logic [CNT_W-1:0] load_count;
  logic [CNT_W-1:0] store_count;

  modport master (
    output M, WB, Add_result, zero, Alu_result, Dato2, Direccion,
    input  pc_src, branch_target, WB_out, Read_data_out, Alu_result_out,
           Direccion_out, mem_fault, fault_addr, load_count, store_count
  );

  modport slave (
    input  M, WB, Add_result, zero, Alu_result, Dato2, Direccion,
    output pc_src, branch_target, WB_out, Read_data_out, Alu_result_out,
           Direccion_out, mem_fault, fault_addr, load_count, store_count
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS-32 memory-access stage: branch resolution, word loads/stores against
// an internal data RAM, illegal-access detection and the MEM/WB register.
module mem_stage #(
  parameter int ADDR_BITS = 8,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);

  localparam int RAM_WORDS = 2 ** ADDR_BITS;

  logic [31:0]          ram [RAM_WORDS];
  logic [ADDR_BITS-1:0] idx;
  logic                 mem_access;
  logic                 misaligned;
  logic                 out_of_range;
  logic                 illegal;
  logic                 fault;
  logic                 do_load;
  logic                 do_store;
  logic [31:0]          rd_word;

  logic [2:0]           wb_q;
  logic [31:0]          read_data_q;
  logic [31:0]          alu_result_q;
  logic [4:0]           direccion_q;
  logic                 mem_fault_q;
  logic [31:0]          fault_addr_q;
  logic [CNT_W-1:0]     load_cnt_q;
  logic [CNT_W-1:0]     store_cnt_q;

  // Branch decision is purely combinational; the target is forwarded as-is.
  always_comb begin
    bus.pc_src        = bus.M[2] & bus.zero;
    bus.branch_target = bus.Add_result;
  end

  // Address decode and access classification for the current instruction.
  always_comb begin
    idx          = bus.Alu_result[ADDR_BITS+1:2];
    mem_access   = bus.M[1] | bus.M[0];
    misaligned   = |bus.Alu_result[1:0];
    out_of_range = |bus.Alu_result[31:ADDR_BITS+2];
    illegal      = bus.M[1] & bus.M[0];
    fault        = mem_access & (misaligned | out_of_range | illegal);
    do_load      = bus.M[1] & ~fault;
    do_store     = bus.M[0] & ~fault;
    rd_word      = ram[idx];
  end

  // RAM write port; a held reset suppresses any store presented at the edge.
  always_ff @(posedge clk) begin
    if (!rst && do_store) begin
      ram[idx] <= bus.Dato2;
    end
  end

  // MEM/WB register, sticky fault capture and saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q         <= '0;
      read_data_q  <= '0;
      alu_result_q <= '0;
      direccion_q  <= '0;
      mem_fault_q  <= 1'b0;
      fault_addr_q <= '0;
      load_cnt_q   <= '0;
      store_cnt_q  <= '0;
    end else begin
      wb_q         <= fault ? 3'b000 : bus.WB;
      read_data_q  <= do_load ? rd_word : 32'd0;
      alu_result_q <= bus.Alu_result;
      direccion_q  <= bus.Direccion;
      if (fault && !mem_fault_q) begin
        mem_fault_q  <= 1'b1;
        fault_addr_q <= bus.Alu_result;
      end
      if (do_load && (load_cnt_q != '1)) begin
        load_cnt_q <= load_cnt_q + CNT_W'(1);
      end
      if (do_store && (store_cnt_q != '1)) begin
        store_cnt_q <= store_cnt_q + CNT_W'(1);
      end
    end
  end

  // Registered state onto the bus.
  always_comb begin
    bus.WB_out         = wb_q;
    bus.Read_data_out  = read_data_q;
    bus.Alu_result_out = alu_result_q;
    bus.Direccion_out  = direccion_q;
    bus.mem_fault      = mem_fault_q;
    bus.fault_addr     = fault_addr_q;
    bus.load_count     = load_cnt_q;
    bus.store_count    = store_cnt_q;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Table-driven bench for mem_stage, plus hand sequences for async reset,
// reset-suppressed store and counter saturation (second instance, CNT_W=2).
module tb_mem_stage;

  logic clk;
  logic rst;

  int unsigned n_checks;
  int unsigned n_errors;

  mem_stage_if #(.CNT_W(16)) bus  ();
  mem_stage_if #(.CNT_W(2))  bus2 ();

  mem_stage #(.ADDR_BITS(8), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_stage #(.ADDR_BITS(8), .CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  assign bus2.M          = bus.M;
  assign bus2.WB         = bus.WB;
  assign bus2.Add_result = bus.Add_result;
  assign bus2.zero       = bus.zero;
  assign bus2.Alu_result = bus.Alu_result;
  assign bus2.Dato2      = bus.Dato2;
  assign bus2.Direccion  = bus.Direccion;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (actual=timeout required=finish)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  m;
    logic [2:0]  wb;
    logic [31:0] add;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] d2;
    logic [4:0]  dir;
    logic        e_pc;
    logic [2:0]  e_wb;
    logic [31:0] e_rd;
    logic [31:0] e_alu;
    logic [4:0]  e_dir;
    logic        e_flt;
    logic [31:0] e_fa;
    logic [15:0] e_lc;
    logic [15:0] e_sc;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " WB_out"},         32'(bus.WB_out),         32'd0);
    check({tag, " Read_data_out"},  bus.Read_data_out,       32'd0);
    check({tag, " Alu_result_out"}, bus.Alu_result_out,      32'd0);
    check({tag, " Direccion_out"},  32'(bus.Direccion_out),  32'd0);
    check({tag, " mem_fault"},      32'(bus.mem_fault),      32'd0);
    check({tag, " fault_addr"},     bus.fault_addr,          32'd0);
    check({tag, " load_count"},     32'(bus.load_count),     32'd0);
    check({tag, " store_count"},    32'(bus.store_count),    32'd0);
  endtask

  task automatic drive(input logic [2:0] m, input logic [2:0] wb, input logic [31:0] add,
                       input logic z, input logic [31:0] alu, input logic [31:0] d2,
                       input logic [4:0] dir);
    bus.M          = m;
    bus.WB         = wb;
    bus.Add_result = add;
    bus.zero       = z;
    bus.Alu_result = alu;
    bus.Dato2      = d2;
    bus.Direccion  = dir;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    //          m       wb      add        z     alu           d2            dir    pc    e_wb    e_rd          e_alu         e_dir  flt   fa     lc  sc
    vecs[0]  = '{3'b001, 3'b000, 32'h0,    1'b0, 32'h10,       32'hDEADBEEF, 5'd1,  1'b0, 3'b000, 32'h0,        32'h10,       5'd1,  1'b0, 32'h0,  16'd0, 16'd1};
    vecs[1]  = '{3'b010, 3'b101, 32'h0,    1'b0, 32'h10,       32'h0,        5'd9,  1'b0, 3'b101, 32'hDEADBEEF, 32'h10,       5'd9,  1'b0, 32'h0,  16'd1, 16'd1};
    vecs[2]  = '{3'b100, 3'b000, 32'h400,  1'b1, 32'h20,       32'h0,        5'd2,  1'b1, 3'b000, 32'h0,        32'h20,       5'd2,  1'b0, 32'h0,  16'd1, 16'd1};
    vecs[3]  = '{3'b100, 3'b000, 32'h400,  1'b0, 32'h20,       32'h0,        5'd2,  1'b0, 3'b000, 32'h0,        32'h20,       5'd2,  1'b0, 32'h0,  16'd1, 16'd1};
    vecs[4]  = '{3'b010, 3'b010, 32'h0,    1'b0, 32'h10,       32'h0,        5'd3,  1'b0, 3'b010, 32'hDEADBEEF, 32'h10,       5'd3,  1'b0, 32'h0,  16'd2, 16'd1};
    vecs[5]  = '{3'b000, 3'b100, 32'h0,    1'b0, 32'h1234,     32'h0,        5'd4,  1'b0, 3'b100, 32'h0,        32'h1234,     5'd4,  1'b0, 32'h0,  16'd2, 16'd1};
    vecs[6]  = '{3'b001, 3'b111, 32'h0,    1'b0, 32'h13,       32'h11111111, 5'd5,  1'b0, 3'b000, 32'h0,        32'h13,       5'd5,  1'b1, 32'h13, 16'd2, 16'd1};
    vecs[7]  = '{3'b010, 3'b001, 32'h0,    1'b0, 32'h10,       32'h0,        5'd6,  1'b0, 3'b001, 32'hDEADBEEF, 32'h10,       5'd6,  1'b1, 32'h13, 16'd3, 16'd1};
    vecs[8]  = '{3'b010, 3'b011, 32'h0,    1'b0, 32'h00010000, 32'h0,        5'd7,  1'b0, 3'b000, 32'h0,        32'h00010000, 5'd7,  1'b1, 32'h13, 16'd3, 16'd1};
    vecs[9]  = '{3'b011, 3'b111, 32'h0,    1'b0, 32'h20,       32'h0,        5'd8,  1'b0, 3'b000, 32'h0,        32'h20,       5'd8,  1'b1, 32'h13, 16'd3, 16'd1};
    vecs[10] = '{3'b001, 3'b001, 32'h0,    1'b0, 32'h3FC,      32'hCAFEF00D, 5'd10, 1'b0, 3'b001, 32'h0,        32'h3FC,      5'd10, 1'b1, 32'h13, 16'd3, 16'd2};
    vecs[11] = '{3'b010, 3'b011, 32'h0,    1'b0, 32'h3FC,      32'h0,        5'd11, 1'b0, 3'b011, 32'hCAFEF00D, 32'h3FC,      5'd11, 1'b1, 32'h13, 16'd4, 16'd2};
    vecs[12] = '{3'b001, 3'b101, 32'h0,    1'b0, 32'h400,      32'h0,        5'd12, 1'b0, 3'b000, 32'h0,        32'h400,      5'd12, 1'b1, 32'h13, 16'd4, 16'd2};
    vecs[13] = '{3'b000, 3'b110, 32'h0,    1'b0, 32'h7,        32'h0,        5'd13, 1'b0, 3'b110, 32'h0,        32'h7,        5'd13, 1'b1, 32'h13, 16'd4, 16'd2};
    vecs[14] = '{3'b110, 3'b001, 32'h8,    1'b1, 32'h10,       32'h0,        5'd14, 1'b1, 3'b001, 32'hDEADBEEF, 32'h10,       5'd14, 1'b1, 32'h13, 16'd5, 16'd2};

    // Reset at start
    drive(3'b000, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
    rst = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table: apply at negedge, check combinational outputs, then registered after the edge
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].m, vecs[i].wb, vecs[i].add, vecs[i].zero, vecs[i].alu, vecs[i].d2, vecs[i].dir);
      #1;
      check($sformatf("v%0d pc_src", i),        32'(bus.pc_src),        32'(vecs[i].e_pc));
      check($sformatf("v%0d branch_target", i), bus.branch_target,      vecs[i].add);
      @(posedge clk);
      #1;
      check($sformatf("v%0d WB_out", i),         32'(bus.WB_out),        32'(vecs[i].e_wb));
      check($sformatf("v%0d Read_data_out", i),  bus.Read_data_out,      vecs[i].e_rd);
      check($sformatf("v%0d Alu_result_out", i), bus.Alu_result_out,     vecs[i].e_alu);
      check($sformatf("v%0d Direccion_out", i),  32'(bus.Direccion_out), 32'(vecs[i].e_dir));
      check($sformatf("v%0d mem_fault", i),      32'(bus.mem_fault),     32'(vecs[i].e_flt));
      check($sformatf("v%0d fault_addr", i),     bus.fault_addr,         vecs[i].e_fa);
      check($sformatf("v%0d load_count", i),     32'(bus.load_count),    32'(vecs[i].e_lc));
      check($sformatf("v%0d store_count", i),    32'(bus.store_count),   32'(vecs[i].e_sc));
      @(negedge clk);
    end

    // Async reset between edges with a store pending; held across an edge
    drive(3'b001, 3'b111, 32'h0, 1'b0, 32'h10, 32'h55555555, 5'd3);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    check_all_zero("reset_held");
    @(negedge clk);
    rst = 1'b0;
    drive(3'b010, 3'b001, 32'h0, 1'b0, 32'h10, 32'h0, 5'd1);
    @(posedge clk);
    #1;
    check("reset_blocks_store Read_data_out", bus.Read_data_out, 32'hDEADBEEF);
    check("reset_blocks_store load_count", 32'(bus.load_count), 32'd1);
    check("reset_blocks_store store_count", 32'(bus.store_count), 32'd0);

    // Saturation: five back-to-back stores
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(3'b001, 3'b000, 32'h0, 1'b0, 32'h0, 32'(k), 5'd0);
      @(posedge clk);
      #1;
      check($sformatf("sat%0d store_count CNT_W=2", k), 32'(bus2.store_count), (k < 3) ? 32'(k + 1) : 32'd3);
      check($sformatf("sat%0d store_count CNT_W=16", k), 32'(bus.store_count), 32'(k + 1));
      @(negedge clk);
    end
    drive(3'b010, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
    @(posedge clk);
    #1;
    check("sat last store data", bus.Read_data_out, 32'd4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
